// File: rtl/lcd_pkg.sv
// Shared constants for the LCD display RAM write-port arbiter.
package lcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_TURN  = 2'd2;

    localparam int LCD_NREQ      = 3;
    localparam int LCD_AW        = 8;
    localparam int LCD_DW        = 8;
    localparam int LCD_MAX_BURST = 16;

endpackage

// File: rtl/lcd_rr_pick.sv
// Combinational circular first-one finder: first set req at or after rr_ptr.
module lcd_rr_pick
    import lcd_pkg::*;
#(
    parameter int NREQ = LCD_NREQ,
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] pick,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic          found;
    logic [IW-1:0] cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        valid = |req;
        found = 1'b0;
        cand  = '0;
        for (int j = 0; j < NREQ; j++) begin
            cand = IW'((int'(rr_ptr) + j) % NREQ);
            if (!found && req[cand]) begin
                found      = 1'b1;
                pick[cand] = 1'b1;
                idx        = cand;
            end
        end
    end

endmodule

// File: rtl/lcd_ram_arbiter.sv
// Round-robin, burst-locked arbiter for the single LCD display RAM write port.
// state    | meaning
// ST_IDLE  | no owner; pick next requester from rr pointer
// ST_GRANT | owner holds gnt; its writes go to RAM with 1-cycle latency
// ST_TURN  | one dead cycle after release before the next pick
module lcd_ram_arbiter
    import lcd_pkg::*;
#(
    parameter int NREQ      = LCD_NREQ,
    parameter int AW        = LCD_AW,
    parameter int DW        = LCD_DW,
    parameter int MAX_BURST = LCD_MAX_BURST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    wr,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] din,
    input  logic             err_clr,
    output logic [NREQ-1:0]  gnt,
    output logic             ram_we,
    output logic [AW-1:0]    ram_addr,
    output logic [DW-1:0]    ram_din,
    output logic             busy,
    output logic             err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    logic [1:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ram_we_q, ram_we_d;
    logic [AW-1:0]   ram_addr_q, ram_addr_d;
    logic [DW-1:0]   ram_din_q, ram_din_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] pick;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    logic            own_req, own_wr;
    logic [AW-1:0]   own_addr;
    logic [DW-1:0]   own_din;

    lcd_rr_pick #(.NREQ(NREQ)) u_pick (
        .req    (req),
        .rr_ptr (rr_q),
        .pick   (pick),
        .idx    (pick_idx),
        .valid  (pick_valid)
    );

    always_comb begin
        own_req  = 1'b0;
        own_wr   = 1'b0;
        own_addr = '0;
        own_din  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (owner_q == IW'(i)) begin
                own_req  = req[i];
                own_wr   = wr[i];
                own_addr = addr[i*AW +: AW];
                own_din  = din[i*DW +: DW];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        count_d    = count_q;
        ram_we_d   = 1'b0;
        ram_addr_d = ram_addr_q;
        ram_din_d  = ram_din_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    count_d = '0;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (own_wr) begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = own_addr;
                    ram_din_d  = own_din;
                    count_d    = count_q + CW'(1);
                end
                // The beat that reaches MAX_BURST is still written; release follows it.
                if (!own_req || count_d == CW'(MAX_BURST)) begin
                    gnt_d   = '0;
                    rr_d    = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
                    state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                state_d = ST_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        if (|(wr & ~gnt_q)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end else begin
            err_d = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            owner_q    <= '0;
            rr_q       <= '0;
            count_q    <= '0;
            ram_we_q   <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            count_q    <= count_d;
            ram_we_q   <= ram_we_d;
            ram_addr_q <= ram_addr_d;
            ram_din_q  <= ram_din_d;
            err_q      <= err_d;
        end
    end

    assign gnt      = gnt_q;
    assign ram_we   = ram_we_q;
    assign ram_addr = ram_addr_q;
    assign ram_din  = ram_din_q;
    assign busy     = (state_q != ST_IDLE);
    assign err      = err_q;

endmodule

// File: tb/tb_lcd_ram_arbiter.sv
// Bench for lcd_ram_arbiter: two instances (MAX_BURST 16 and 4) share one stimulus
// and are checked every cycle against a behavioural model, plus literal expectations.
module tb_lcd_ram_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req, wr;
    logic [23:0] addr, din;
    logic        err_clr;

    logic [2:0]  gnt_a, gnt_b;
    logic        we_a, we_b, busy_a, busy_b, err_a, err_b;
    logic [7:0]  ra_a, ra_b, rd_a, rd_b;

    always #5 clk = ~clk;

    lcd_ram_arbiter #(.NREQ(3), .AW(8), .DW(8), .MAX_BURST(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .din(din),
        .err_clr(err_clr), .gnt(gnt_a), .ram_we(we_a), .ram_addr(ra_a),
        .ram_din(rd_a), .busy(busy_a), .err(err_a)
    );

    lcd_ram_arbiter #(.NREQ(3), .AW(8), .DW(8), .MAX_BURST(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .din(din),
        .err_clr(err_clr), .gnt(gnt_b), .ram_we(we_b), .ram_addr(ra_b),
        .ram_din(rd_b), .busy(busy_b), .err(err_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model; index 0 mirrors dut_a (burst 16), index 1 dut_b (burst 4).
    // phase: 0 = nobody owns, 1 = owner holds grant, 2 = gap after release
    int         m_phase[2], m_owner[2], m_cnt[2], m_rr[2];
    logic [2:0] m_gnt[2];
    logic       m_we[2], m_err[2];
    logic [7:0] m_addr[2], m_din[2];

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = 0; m_owner[k] = 0; m_cnt[k] = 0; m_rr[k] = 0;
            m_gnt[k] = 3'b000; m_we[k] = 1'b0; m_err[k] = 1'b0;
            m_addr[k] = 8'h00; m_din[k] = 8'h00;
        end
    endtask

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            int   mb;
            int   o;
            int   c;
            logic found;
            logic viol;
            mb    = (k == 0) ? 16 : 4;
            viol  = ((wr & ~m_gnt[k]) != 3'b000);
            m_we[k] = 1'b0;
            found = 1'b0;
            o     = m_owner[k];
            if (m_phase[k] == 0) begin
                for (int j = 0; j < 3; j++) begin
                    c = (m_rr[k] + j) % 3;
                    if (!found && req[c[1:0]]) begin
                        found      = 1'b1;
                        m_owner[k] = c;
                        m_gnt[k]   = 3'(1 << c);
                        m_cnt[k]   = 0;
                        m_phase[k] = 1;
                    end
                end
            end else if (m_phase[k] == 1) begin
                if (wr[o[1:0]]) begin
                    m_we[k]   = 1'b1;
                    m_addr[k] = 8'(addr >> (8 * o));
                    m_din[k]  = 8'(din >> (8 * o));
                    m_cnt[k]  = m_cnt[k] + 1;
                end
                if (!req[o[1:0]] || m_cnt[k] == mb) begin
                    m_gnt[k]   = 3'b000;
                    m_rr[k]    = (o + 1) % 3;
                    m_phase[k] = 2;
                end
            end else begin
                m_phase[k] = 0;
            end
            if (viol) m_err[k] = 1'b1;
            else if (err_clr) m_err[k] = 1'b0;
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else m_step();
        end
    end

    logic [15:0] wlog_a[$];
    logic [15:0] wlog_b[$];

    task automatic cmp_one(int k, logic [2:0] g, logic we, logic [7:0] a, logic [7:0] d,
                           logic b, logic e);
        chk($sformatf("gnt[%0d]", k), {29'd0, g}, {29'd0, m_gnt[k]});
        chk($sformatf("ram_we[%0d]", k), {31'd0, we}, {31'd0, m_we[k]});
        chk($sformatf("busy[%0d]", k), {31'd0, b}, {31'd0, (m_phase[k] != 0)});
        chk($sformatf("err[%0d]", k), {31'd0, e}, {31'd0, m_err[k]});
        if (m_we[k]) begin
            chk($sformatf("ram_addr[%0d]", k), {24'd0, a}, {24'd0, m_addr[k]});
            chk($sformatf("ram_din[%0d]", k), {24'd0, d}, {24'd0, m_din[k]});
        end
    endtask

    always @(negedge clk) begin
        cmp_one(0, gnt_a, we_a, ra_a, rd_a, busy_a, err_a);
        cmp_one(1, gnt_b, we_b, ra_b, rd_b, busy_b, err_b);
        if (we_a === 1'b1) wlog_a.push_back({ra_a, rd_a});
        if (we_b === 1'b1) wlog_b.push_back({ra_b, rd_b});
    end

    task automatic cyc(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_w(int i, logic [7:0] a, logic [7:0] d);
        addr[i*8 +: 8] = a;
        din[i*8 +: 8]  = d;
    endtask

    task automatic do_reset();
        req = 3'b000; wr = 3'b000; addr = '0; din = '0; err_clr = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        wlog_a.delete();
        wlog_b.delete();
    endtask

    logic [7:0] rec[10];
    int         idx, t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rec = '{8'h08, 8'h00, 8'h4A, 8'h61, 8'h62, 8'h6F, 8'h6E, 8'h20, 8'h24, 8'h04};
        req = 3'b000; wr = 3'b000; addr = '0; din = '0; err_clr = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        chk("rst_gnt", {29'd0, gnt_a}, 32'd0);
        chk("rst_we", {31'd0, we_a}, 32'd0);
        chk("rst_addr", {24'd0, ra_a}, 32'd0);
        chk("rst_din", {24'd0, rd_a}, 32'd0);
        chk("rst_busy", {31'd0, busy_a}, 32'd0);
        chk("rst_err", {31'd0, err_b}, 32'd0);

        // 1: ten-byte record from requester 0
        do_reset();
        req = 3'b001;
        cyc(1);
        chk("t1_gnt", {29'd0, gnt_a}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            wr = 3'b001;
            set_w(0, 8'(k), rec[k]);
            cyc(1);
        end
        wr = 3'b000; req = 3'b000;
        cyc(1);
        chk("t1_release", {29'd0, gnt_a}, 32'd0);
        cyc(3);
        chk("t1_count", wlog_a.size(), 32'd10);
        for (int k = 0; k < 10 && k < wlog_a.size(); k++)
            chk($sformatf("t1_write%0d", k), {16'd0, wlog_a[k]}, {16'd0, 8'(k), rec[k]});

        // 2: round robin after simultaneous request
        do_reset();
        req = 3'b011;
        cyc(1);
        chk("t2_first", {29'd0, gnt_a}, 32'd1);
        cyc(1);
        req = 3'b010;
        cyc(1);
        chk("t2_gap1", {29'd0, gnt_a}, 32'd0);
        req = 3'b011;
        cyc(1);
        chk("t2_gap2", {29'd0, gnt_a}, 32'd0);
        cyc(1);
        chk("t2_rr", {29'd0, gnt_a}, 32'd2);
        req = 3'b000;
        cyc(3);

        // 3: burst limit on the MAX_BURST=4 instance
        do_reset();
        req = 3'b001;
        cyc(1);
        for (int k = 0; k < 6; k++) begin
            wr = 3'b001;
            set_w(0, 8'h10 + 8'(k), 8'hA0 + 8'(k));
            cyc(1);
            if (k == 3) chk("t3_gnt_drop", {29'd0, gnt_b}, 32'd0);
        end
        wr = 3'b000;
        cyc(1);
        chk("t3_err_b", {31'd0, err_b}, 32'd1);
        chk("t3_err_a", {31'd0, err_a}, 32'd0);
        req = 3'b000;
        cyc(3);
        chk("t3_count_b", wlog_b.size(), 32'd4);
        for (int k = 0; k < 4 && k < wlog_b.size(); k++)
            chk($sformatf("t3_addr%0d", k), {24'd0, wlog_b[k][15:8]}, 32'h10 + k);
        chk("t3_count_a", wlog_a.size(), 32'd6);

        // 4: stray write from a non-owner, then err_clr
        do_reset();
        req = 3'b001;
        cyc(1);
        wr = 3'b011;
        set_w(0, 8'h20, 8'h55);
        set_w(1, 8'h30, 8'h99);
        cyc(1);
        chk("t4_err", {31'd0, err_a}, 32'd1);
        chk("t4_addr", {24'd0, ra_a}, 32'h20);
        wr = 3'b001;
        set_w(0, 8'h21, 8'h56);
        err_clr = 1'b1;
        cyc(1);
        chk("t4_clr", {31'd0, err_a}, 32'd0);
        err_clr = 1'b0;
        set_w(0, 8'h22, 8'h57);
        cyc(1);
        chk("t4_err_low", {31'd0, err_a}, 32'd0);
        chk("t4_owner_wr", {24'd0, ra_a}, 32'h22);
        wr = 3'b000; req = 3'b000;
        cyc(3);
        chk("t4_count", wlog_a.size(), 32'd3);

        // 5: asynchronous reset mid-burst
        do_reset();
        req = 3'b001;
        cyc(1);
        for (int k = 0; k < 3; k++) begin
            wr = 3'b001;
            set_w(0, 8'h40 + 8'(k), 8'hC0 + 8'(k));
            cyc(1);
        end
        wr = 3'b001;
        set_w(0, 8'h43, 8'hC3);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_gnt", {29'd0, gnt_a}, 32'd0);
        chk("t5_we", {31'd0, we_a}, 32'd0);
        chk("t5_busy", {31'd0, busy_a}, 32'd0);
        chk("t5_gnt_b", {29'd0, gnt_b}, 32'd0);
        wr = 3'b000;
        req = 3'b101;
        cyc(1);
        rst_n = 1'b1;
        cyc(1);
        chk("t5_rr0", {29'd0, gnt_a}, 32'd1);
        chk("t5_rr0_b", {29'd0, gnt_b}, 32'd1);
        req = 3'b000;
        cyc(4);

        // 6: three persistent requesters, two writes per grant
        do_reset();
        req = 3'b111;
        for (int g = 0; g < 6; g++) begin
            t = 0;
            while (gnt_a == 3'b000 && t < 10) begin
                cyc(1);
                t++;
            end
            chk($sformatf("t6_grant_seen%0d", g), {31'd0, (gnt_a != 3'b000)}, 32'd1);
            idx = 0;
            for (int j = 0; j < 3; j++) if (gnt_a[j]) idx = j;
            chk($sformatf("t6_order%0d", g), idx, g % 3);
            wr = gnt_a;
            set_w(idx, 8'h50 + 8'(2 * g), 8'h11);
            cyc(1);
            set_w(idx, 8'h51 + 8'(2 * g), 8'h22);
            cyc(1);
            wr = 3'b000;
            req = 3'b111 & ~gnt_a;
            cyc(1);
            req = 3'b111;
        end
        req = 3'b000;
        cyc(4);
        chk("t6_writes", wlog_a.size(), 32'd12);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
